lectura_rtc_ctrl: RTL and testbench

LECTURA_RTC_CTRL -- requirements
Module: lectura_rtc_ctrl

---
 rtl/lectura_rtc_ctrl_if.sv | 36 +++
 rtl/lectura_rtc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lectura_rtc_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lectura_rtc_ctrl_if.sv
// ---------------------------------------------------------------------------
// lectura_rtc_ctrl_if
//
// Purpose: groups the read handshake between the RTC sweep controller and the
// RTC bus driver into one bundle.
//
// Signals:
//   bus_req   1  one-cycle request for a bus read cycle (controller -> driver)
//   bus_addr  8  RTC register address, valid with bus_req and while waiting
//   bus_done  1  one-cycle completion pulse (driver -> controller)
//   bus_dato  8  byte read from the RTC, valid in the bus_done cycle
//
// Modports:
//   master  the sweep controller (drives bus_req/bus_addr)
//   slave   the bus driver (drives bus_done/bus_dato)
// ---------------------------------------------------------------------------
interface lectura_rtc_ctrl_if;
  logic       bus_req;
  logic [7:0] bus_addr;
  logic       bus_done;
  logic [7:0] bus_dato;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_done,
    input  bus_dato
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_done,
    output bus_dato
  );
endinterface

// File: rtl/lectura_rtc_ctrl.sv
// ---------------------------------------------------------------------------
// lectura_rtc_ctrl
//
// Purpose: on a start request, reads a fixed list of RTC registers one after
// the other through an external bus driver and loads each captured byte into
// a register bank (one LL_signal strobe per register). A read that gets no
// bus_done within TIMEOUT_CYC cycles aborts the sweep and raises a sticky
// error flag.
//
// Parameters:
//   TIMEOUT_CYC  max cycles spent waiting for bus_done (1..255, default 255)
//
// Configuration macro:
//   RTC_TIMER_READ_EN  defined   -> sweep covers indices 1..9 (time + timer)
//                      undefined -> sweep covers indices 1..6 (time only)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       sweep request, sampled only while idle
//   bus         lectura_rtc_ctrl_if.master, handshake to the RTC bus driver
//   reg_select  register-bank index 1..LAST, 0 while idle
//   LL_signal   one-cycle load strobe to the register bank
//   dato_rtc    last captured byte
//   busy        high whenever a sweep is in progress
//   ciclo_fin   one-cycle pulse at the end of every sweep (done or aborted)
//   error       sticky timeout flag, cleared by reset or the next start
// ---------------------------------------------------------------------------
module lectura_rtc_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  lectura_rtc_ctrl_if.master        bus,
  output logic [3:0]                reg_select,
  output logic                      LL_signal,
  output logic [7:0]                dato_rtc,
  output logic                      busy,
  output logic                      ciclo_fin,
  output logic                      error
);

`ifdef RTC_TIMER_READ_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd6;
`endif

  // One bit wider than the counter so the limit compare can never wrap.
  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    LATCH,
    NEXT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] index_q, index_d;
  logic [7:0] count_q, count_d;
  logic [7:0] dato_q,  dato_d;
  logic       error_q, error_d;

  // Bank index to RTC register address: 0x21..0x26 are the clock/calendar
  // registers, 0x41..0x43 the timer registers.
  function automatic logic [7:0] addr_map(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd1:    a = 8'h21;
      4'd2:    a = 8'h22;
      4'd3:    a = 8'h23;
      4'd4:    a = 8'h24;
      4'd5:    a = 8'h25;
      4'd6:    a = 8'h26;
      4'd7:    a = 8'h41;
      4'd8:    a = 8'h42;
      4'd9:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= 4'd0;
      count_q <= 8'd0;
      dato_q  <= 8'h00;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      dato_q  <= dato_d;
      error_q <= error_d;
    end
  end

  // Next-state logic. In WAIT the bus_done test comes first so a reply that
  // lands on the last allowed cycle is still accepted rather than timed out.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    dato_d  = dato_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          index_d = 4'd1;
          count_d = 8'd0;
          error_d = 1'b0;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        count_d = count_q + 8'd1;
        if (bus.bus_done) begin
          dato_d  = bus.bus_dato;
          state_d = LATCH;
        end else if (({1'b0, count_q} + 9'd1) >= TIMEOUT_W) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      LATCH: begin
        state_d = NEXT;
      end
      NEXT: begin
        count_d = 8'd0;
        if (index_q == LAST) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 4'd1;
          state_d = REQ;
        end
      end
      DONE: begin
        // index is still reported during DONE; park it once back in IDLE.
        index_d = 4'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs, decoded from the registered state only.
  always_comb begin
    bus.bus_req  = (state_q == REQ);
    bus.bus_addr = 8'h00;
    if ((state_q == REQ) || (state_q == WAIT)) begin
      bus.bus_addr = addr_map(index_q);
    end
    reg_select = (state_q == IDLE) ? 4'd0 : index_q;
    LL_signal  = (state_q == LATCH);
    busy       = (state_q != IDLE);
    ciclo_fin  = (state_q == DONE);
    dato_rtc   = dato_q;
    error      = error_q;
  end

endmodule

// File: tb/tb_lectura_rtc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lectura_rtc_ctrl
//
// Three controller instances share clock and reset:
//   dutA  default TIMEOUT_CYC, used for the normal sweep scenarios
//   dutB  TIMEOUT_CYC=4, used for the aborted-read scenario
//   dutC  TIMEOUT_CYC=2, used for bus_done arriving on the limit cycle
// Honours RTC_TIMER_READ_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_lectura_rtc_ctrl;

`ifdef RTC_TIMER_READ_EN
  localparam int LAST = 9;
`else
  localparam int LAST = 6;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset  = 1'b1;
  logic startA = 1'b0;
  logic startB = 1'b0;
  logic startC = 1'b0;

  logic [3:0] regSelA, regSelB, regSelC;
  logic       llA, llB, llC;
  logic [7:0] datoA, datoB, datoC;
  logic       busyA, busyB, busyC;
  logic       finA, finB, finC;
  logic       errA, errB, errC;

  lectura_rtc_ctrl_if busA ();
  lectura_rtc_ctrl_if busB ();
  lectura_rtc_ctrl_if busC ();

  lectura_rtc_ctrl dutA (
    .clk(clk), .reset(reset), .start(startA), .bus(busA),
    .reg_select(regSelA), .LL_signal(llA), .dato_rtc(datoA),
    .busy(busyA), .ciclo_fin(finA), .error(errA)
  );

  lectura_rtc_ctrl #(.TIMEOUT_CYC(4)) dutB (
    .clk(clk), .reset(reset), .start(startB), .bus(busB),
    .reg_select(regSelB), .LL_signal(llB), .dato_rtc(datoB),
    .busy(busyB), .ciclo_fin(finB), .error(errB)
  );

  lectura_rtc_ctrl #(.TIMEOUT_CYC(2)) dutC (
    .clk(clk), .reset(reset), .start(startC), .bus(busC),
    .reg_select(regSelC), .LL_signal(llC), .dato_rtc(datoC),
    .busy(busyC), .ciclo_fin(finC), .error(errC)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {expected reg_select, expected dato_rtc}.
  logic [11:0] scoreQ[$];
  int          reqCntA;
  logic        pendA;
  logic [3:0]  pendIdxA;
  logic [7:0]  lastDatoA;

  function automatic logic [7:0] addrMap(input int k);
    logic [7:0] a;
    case (k)
      1: a = 8'h21;
      2: a = 8'h22;
      3: a = 8'h23;
      4: a = 8'h24;
      5: a = 8'h25;
      6: a = 8'h26;
      7: a = 8'h41;
      8: a = 8'h42;
      9: a = 8'h43;
      default: a = 8'hFF;
    endcase
    return a;
  endfunction

  task automatic clearA();
    scoreQ.delete();
    reqCntA  = 0;
    pendA    = 1'b0;
    pendIdxA = 4'd0;
  endtask

  // Bus driver model for dutA: answers every request in the following cycle
  // with data 0x10+index and records the load that should follow.
  task automatic stepA();
    @(negedge clk);
    busA.bus_done = 1'b0;
    if (pendA) begin
      busA.bus_done = 1'b1;
      busA.bus_dato = {4'h1, pendIdxA};
      scoreQ.push_back({pendIdxA, 4'h1, pendIdxA});
    end
    pendA = 1'b0;
    if (busA.bus_req) begin
      reqCntA++;
      pendIdxA = 4'(reqCntA);
      pendA    = 1'b1;
    end
  endtask

  task automatic quietReset();
    reset  = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
    busA.bus_done = 1'b0;
    busB.bus_done = 1'b0;
    busC.bus_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clearA();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
    busA.bus_done = 1'b0; busA.bus_dato = 8'h00;
    busB.bus_done = 1'b0; busB.bus_dato = 8'h00;
    busC.bus_done = 1'b0; busC.bus_dato = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (busA.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req: got %b expected 0", busA.bus_req); end
    checks++;
    if (busA.bus_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_bus_addr: got %h expected 00", busA.bus_addr); end
    checks++;
    if (regSelA !== 4'd0) begin errors++; $display("[TB] FAIL reset_reg_select: got %0d expected 0", regSelA); end
    checks++;
    if (llA !== 1'b0) begin errors++; $display("[TB] FAIL reset_LL_signal: got %b expected 0", llA); end
    checks++;
    if (datoA !== 8'h00) begin errors++; $display("[TB] FAIL reset_dato_rtc: got %h expected 00", datoA); end
    checks++;
    if ({busyA, finA, errA} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {busyA, finA, errA}); end
    checks++;
    if ({busB.bus_req, busB.bus_addr, regSelB, llB, datoB, busyB, finB, errB} !== 25'd0) begin
      errors++; $display("[TB] FAIL reset_dutB: got %h expected 0", {busB.bus_req, busB.bus_addr, regSelB, llB, datoB, busyB, finB, errB});
    end
    checks++;
    if ({busC.bus_req, busC.bus_addr, regSelC, llC, datoC, busyC, finC, errC} !== 25'd0) begin
      errors++; $display("[TB] FAIL reset_dutC: got %h expected 0", {busC.bus_req, busC.bus_addr, regSelC, llC, datoC, busyC, finC, errC});
    end
    reset = 1'b0;
    clearA();
  endtask

  task automatic test_full_sweep();
    int         llCnt    = 0;
    int         maxSel   = 0;
    int         finCycle = 0;
    logic [11:0] e;
    clearA();
    startA = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      stepA();
      startA = 1'b0;
      if (busA.bus_req) begin
        checks++;
        if (busA.bus_addr !== addrMap(reqCntA)) begin
          errors++; $display("[TB] FAIL sweep_addr[%0d]: got %h expected %h", reqCntA, busA.bus_addr, addrMap(reqCntA));
        end
      end
      if (int'(regSelA) > maxSel) maxSel = int'(regSelA);
      if (llA) begin
        checks++;
        llCnt++;
        if (scoreQ.size() == 0) begin
          errors++; $display("[TB] FAIL sweep_load: unexpected load sel=%0d dato=%h", regSelA, datoA);
        end else begin
          e = scoreQ.pop_front();
          lastDatoA = e[7:0];
          if ({regSelA, datoA} !== e) begin
            errors++; $display("[TB] FAIL sweep_load: got sel=%0d dato=%h expected sel=%0d dato=%h", regSelA, datoA, e[11:8], e[7:0]);
          end
        end
      end
      if (finA) begin
        finCycle = n;
        break;
      end
    end
    checks++;
    if (finCycle != 4 * LAST + 1) begin errors++; $display("[TB] FAIL sweep_fin_cycle: got %0d expected %0d", finCycle, 4 * LAST + 1); end
    checks++;
    if (llCnt != LAST) begin errors++; $display("[TB] FAIL sweep_load_count: got %0d expected %0d", llCnt, LAST); end
    checks++;
    if (maxSel != LAST) begin errors++; $display("[TB] FAIL sweep_max_sel: got %0d expected %0d", maxSel, LAST); end
    checks++;
    if (errA !== 1'b0) begin errors++; $display("[TB] FAIL sweep_error: got %b expected 0", errA); end
  endtask

  task automatic test_ignored_inputs();
    int   llCnt     = 0;
    int   finCycle  = 0;
    int   extraBusy = 0;
    logic [11:0] e;
    // Stray bus_done while idle.
    busA.bus_done = 1'b1;
    busA.bus_dato = 8'hEE;
    @(negedge clk);
    busA.bus_done = 1'b0;
    checks++;
    if ({llA, busyA, datoA} !== {1'b0, 1'b0, lastDatoA}) begin
      errors++; $display("[TB] FAIL stray_done_idle: got ll=%b busy=%b dato=%h expected ll=0 busy=0 dato=%h", llA, busyA, datoA, lastDatoA);
    end
    // Sweep with a second start pulse in the middle.
    clearA();
    startA = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      stepA();
      startA = (n == 6);
      if (llA) begin
        checks++;
        llCnt++;
        if (scoreQ.size() == 0) begin
          errors++; $display("[TB] FAIL ignored_load: unexpected load sel=%0d", regSelA);
        end else begin
          e = scoreQ.pop_front();
          lastDatoA = e[7:0];
          if ({regSelA, datoA} !== e) begin
            errors++; $display("[TB] FAIL ignored_load: got sel=%0d dato=%h expected sel=%0d dato=%h", regSelA, datoA, e[11:8], e[7:0]);
          end
        end
      end
      if (finA) begin
        finCycle = n;
        break;
      end
    end
    startA = 1'b0;
    checks++;
    if (finCycle != 4 * LAST + 1) begin errors++; $display("[TB] FAIL ignored_fin_cycle: got %0d expected %0d", finCycle, 4 * LAST + 1); end
    for (int n = 0; n < 5; n++) begin
      stepA();
      if (busyA || llA) extraBusy++;
    end
    checks++;
    if (extraBusy != 0) begin errors++; $display("[TB] FAIL ignored_no_resweep: got %0d busy cycles expected 0", extraBusy); end
    busA.bus_done = 1'b1;
    busA.bus_dato = 8'hC3;
    @(negedge clk);
    busA.bus_done = 1'b0;
    checks++;
    if ({llA, datoA} !== {1'b0, lastDatoA}) begin
      errors++; $display("[TB] FAIL stray_done_after: got ll=%b dato=%h expected ll=0 dato=%h", llA, datoA, lastDatoA);
    end
  endtask

  task automatic test_back_to_back();
    bit finished = 0;
    clearA();
    startA = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      stepA();
      if (finA) begin
        finished = 1;
        break;
      end
    end
    checks++;
    if (!finished) begin errors++; $display("[TB] FAIL b2b_first_fin: got no ciclo_fin expected one within 200 cycles"); end
    stepA();
    checks++;
    if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got busy=%b expected 0", busyA); end
    stepA();
    checks++;
    if ({busA.bus_req, busA.bus_addr, regSelA} !== {1'b1, 8'h21, 4'd1}) begin
      errors++; $display("[TB] FAIL b2b_relaunch: got req=%b addr=%h sel=%0d expected req=1 addr=21 sel=1", busA.bus_req, busA.bus_addr, regSelA);
    end
    startA = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    bit hit = 0;
    clearA();
    startA = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      stepA();
      startA = 1'b0;
      if (busA.bus_req && reqCntA == 5) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL mid_reach_idx5: got no request for index 5 expected one"); end
    stepA();
    checks++;
    if ({busyA, regSelA, busA.bus_req, busA.bus_addr} !== {1'b1, 4'd5, 1'b0, 8'h25}) begin
      errors++; $display("[TB] FAIL mid_wait_state: got busy=%b sel=%0d req=%b addr=%h expected busy=1 sel=5 req=0 addr=25", busyA, regSelA, busA.bus_req, busA.bus_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busA.bus_req, busA.bus_addr, regSelA, llA, datoA, busyA, finA, errA} !== 25'd0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got %h expected 0", {busA.bus_req, busA.bus_addr, regSelA, llA, datoA, busyA, finA, errA});
    end
    reset = 1'b0;
    busA.bus_done = 1'b0;
    clearA();
    startA = 1'b1;
    stepA();
    startA = 1'b0;
    checks++;
    if ({busA.bus_req, busA.bus_addr, regSelA} !== {1'b1, 8'h21, 4'd1}) begin
      errors++; $display("[TB] FAIL mid_restart: got req=%b addr=%h sel=%0d expected req=1 addr=21 sel=1", busA.bus_req, busA.bus_addr, regSelA);
    end
  endtask

  task automatic test_timeout();
    int          reqCnt   = 0;
    int          llCnt    = 0;
    int          finCycle = 0;
    logic        pend     = 1'b0;
    logic [3:0]  pendIdx  = 4'd0;
    logic        errAtFin = 1'b0;
    logic [11:0] e;
    scoreQ.delete();
    startB = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      startB = 1'b0;
      busB.bus_done = 1'b0;
      if (pend) begin
        busB.bus_done = 1'b1;
        busB.bus_dato = {4'h3, pendIdx};
        scoreQ.push_back({pendIdx, 4'h3, pendIdx});
      end
      pend = 1'b0;
      if (busB.bus_req) begin
        reqCnt++;
        pendIdx = 4'(reqCnt);
        pend    = (reqCnt != 3);
      end
      if (llB) begin
        checks++;
        llCnt++;
        if (scoreQ.size() == 0) begin
          errors++; $display("[TB] FAIL timeout_load: unexpected load sel=%0d dato=%h", regSelB, datoB);
        end else begin
          e = scoreQ.pop_front();
          if ({regSelB, datoB} !== e) begin
            errors++; $display("[TB] FAIL timeout_load: got sel=%0d dato=%h expected sel=%0d dato=%h", regSelB, datoB, e[11:8], e[7:0]);
          end
        end
      end
      if (finB) begin
        finCycle = n;
        errAtFin = errB;
        break;
      end
    end
    checks++;
    if (finCycle != 14) begin errors++; $display("[TB] FAIL timeout_fin_cycle: got %0d expected 14", finCycle); end
    checks++;
    if (llCnt != 2) begin errors++; $display("[TB] FAIL timeout_load_count: got %0d expected 2", llCnt); end
    checks++;
    if (errAtFin !== 1'b1) begin errors++; $display("[TB] FAIL timeout_error: got %b expected 1", errAtFin); end
    @(negedge clk);
    checks++;
    if ({busyB, regSelB, errB} !== {1'b0, 4'd0, 1'b1}) begin
      errors++; $display("[TB] FAIL timeout_idle: got busy=%b sel=%0d err=%b expected busy=0 sel=0 err=1", busyB, regSelB, errB);
    end
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    checks++;
    if ({errB, busyB, busB.bus_addr} !== {1'b0, 1'b1, 8'h21}) begin
      errors++; $display("[TB] FAIL timeout_restart_clears: got err=%b busy=%b addr=%h expected err=0 busy=1 addr=21", errB, busyB, busB.bus_addr);
    end
  endtask

  task automatic test_coincident();
    startC = 1'b1;
    @(negedge clk);
    startC = 1'b0;
    checks++;
    if ({busC.bus_req, busC.bus_addr} !== {1'b1, 8'h21}) begin
      errors++; $display("[TB] FAIL coinc_req: got req=%b addr=%h expected req=1 addr=21", busC.bus_req, busC.bus_addr);
    end
    @(negedge clk);
    @(negedge clk);
    busC.bus_done = 1'b1;
    busC.bus_dato = 8'h5A;
    @(negedge clk);
    busC.bus_done = 1'b0;
    checks++;
    if ({llC, regSelC, datoC, errC} !== {1'b1, 4'd1, 8'h5A, 1'b0}) begin
      errors++; $display("[TB] FAIL coinc_latch: got ll=%b sel=%0d dato=%h err=%b expected ll=1 sel=1 dato=5a err=0", llC, regSelC, datoC, errC);
    end
    @(negedge clk);
    checks++;
    if ({finC, errC} !== 2'b00) begin errors++; $display("[TB] FAIL coinc_next: got fin=%b err=%b expected fin=0 err=0", finC, errC); end
    @(negedge clk);
    checks++;
    if ({busC.bus_req, busC.bus_addr} !== {1'b1, 8'h22}) begin
      errors++; $display("[TB] FAIL coinc_continue: got req=%b addr=%h expected req=1 addr=22", busC.bus_req, busC.bus_addr);
    end
  endtask

  initial begin
    lastDatoA = 8'h00;
    clearA();
    test_reset();
    test_full_sweep();
    test_ignored_inputs();
    test_back_to_back();
    quietReset();
    test_reset_mid_sweep();
    quietReset();
    test_timeout();
    quietReset();
    test_coincident();
    quietReset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
